snn_ctrl: RTL and testbench
===========================

# snn_ctrl

Top-level sequencer for the SNN digit classifier. It receives a packed 784-pixel image from the UART receiver and unpacks it bit-by-bit into the 1-bit input-unit RAM. It then launches `snn_core`, waits for the result and transmits the digit as ASCII over the UART transmitter. It also arbitrates the input RAM address port between its own write path and the core's read address.

## Interface

Reset is synchronous, active-high. The design uses one clock.

Parameters:
- `NUM_BYTES`, 98: image bytes per frame (784 pixels / 8).
- `ADDR_W`, 10: input RAM address width.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous active-high reset.
- `rx_rdy`  in  1  one-cycle pulse: `rx_data` is valid.
- `rx_data`  in  8  received byte; pixel n of the byte is bit n, LSB first.
- `core_addr`  in  `ADDR_W`  `snn_core` input-unit read address.
- `core_done`  in  1  `snn_core` completion; level or pulse.
- `core_digit`  in  4  `snn_core` classified digit.
- `tx_done`  in  1  one-cycle pulse: UART transmit finished.
- `ram_addr`  out  `ADDR_W`  input RAM address (muxed).
- `ram_we`  out  1  input RAM write enable.
- `ram_data`  out  1  input RAM write data.
- `core_start`  out  1  one-cycle start pulse to `snn_core`.
- `tx_start`  out  1  one-cycle UART transmit request.
- `tx_data`  out  8  ASCII byte, 8'h30 + digit.
- `led`  out  8  {4'h0, last digit}.
- `ovr`  out  1  sticky overrun flag.

## Operation

FSM states and transitions:
- `S_RX`: wait for `rx_rdy`. On the pulse, latch `rx_data` into an 8-bit shift register, clear `bit_cnt`, go to `S_WR`.
- `S_WR`: eight consecutive cycles.
  - Outputs: `ram_we`=1, `ram_addr`={`byte_cnt`[6:0], `bit_cnt`[2:0]}, `ram_data`=shift[0].
  - Shift right and increment `bit_cnt` each cycle.
  - At `bit_cnt`==7: if `byte_cnt`==`NUM_BYTES`-1, go to `S_START`; else increment `byte_cnt` and go to `S_RX`.
- `S_START`: `core_start`=1 for one cycle. Clear `byte_cnt`. Go to `S_RUN`.
- `S_RUN`: `ram_addr`=`core_addr`, `ram_we`=0. On the first cycle `core_done` is high, latch `core_digit` into `digit_reg` and go to `S_TX`.
- `S_TX`: `tx_start`=1 for one cycle, `tx_data`=8'h30+`digit_reg`. Go to `S_TXW`.
- `S_TXW`: wait for `tx_done`, then go to `S_RX` (next frame).

Arbitration and data rules:
- `ram_addr` is `core_addr` only in `S_START`/`S_RUN`. In every other state it is the write address, or 0 when idle.
- The core never sees a write cycle.
- Addresses 784..1023 are never written.
- `led` updates with `digit_reg`.
- `tx_data` is held constant from `S_TX` through `S_TXW`.

Boundary conditions:
- `rx_rdy` in any state other than `S_RX`: the byte is dropped and `ovr` is set. `ovr` is cleared only by `rst`.
- `core_done` already high on entry to `S_RUN`: accepted on that cycle.
- `core_done` in any state other than `S_RUN`: ignored.
- `tx_done` in any state other than `S_TXW`: ignored.
- `rst` mid-frame: all counters clear and the partial image is abandoned. The next `rx_rdy` is treated as byte 0.

## Timing

Reset values: state `S_RX`, `byte_cnt`=0, `bit_cnt`=0, `digit_reg`=0, `ovr`=0. All outputs are 0, except `tx_data`=8'h30.

Latencies:
- `rx_rdy` at cycle t: writes occur at t+1..t+8.
- Last write at cycle t: `core_start` at t+1, `ram_addr` follows `core_addr` from t+1.
- `core_done` seen at t: `tx_start` at t+1.
- `tx_done` at t: ready for `rx_rdy` at t+1.
- Minimum spacing between `rx_rdy` pulses: 9 cycles.

Output timing:
- `ram_we`, `ram_addr`, `ram_data`, `core_start` and `tx_start` are combinational decodes of registered state and counters. They are glitch-free at the clock edge.

## Structure

- Shared `snn_pkg` holds:
  - `ctrl_state_t` enum: `S_RX`, `S_WR`, `S_START`, `S_RUN`, `S_TX`, `S_TXW`.
  - `NUM_PIXELS`=784.
  - `ASCII_ZERO`=8'h30.
- No sub-module. This is a single module with a state register, two counters, a shift register, the digit/`ovr` registers and one `always_comb` next-state/output block.

## Test plan

- Reset: assert `rst` for 2 cycles -> all outputs 0, `tx_data`=8'h30, state `S_RX`, `ovr`=0.
- Load pattern: 98 bytes of 8'hA5 -> RAM bit n = (0xA5>>(n%8))&1 for n=0..783. Last write at address 783. `core_start` is high exactly one cycle, the cycle after.
- Arbitration: during `S_RUN`, drive `core_addr`=10'h1F3 -> `ram_addr`=10'h1F3, `ram_we`=0.
- Result: `core_done`=1 with `core_digit`=7 -> next cycle `tx_start`=1, `tx_data`=8'h37, `led`=8'h07. Then `tx_done` -> returns to `S_RX`. A second frame loads again from address 0.
- Overrun: `rx_rdy` pulse 3 cycles after the previous one (inside `S_WR`) -> `ovr`=1, byte dropped, `byte_cnt` unchanged. `ovr` stays 1 until `rst`.
- Reset mid-load: `rst` after byte 40 -> the next byte is written to addresses 0..7, and `core_start` fires only after 98 further bytes.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN digit classifier: controller states and
// image/ASCII constants.
package snn_pkg;

    typedef enum logic [2:0] {
        S_RX,
        S_WR,
        S_START,
        S_RUN,
        S_TX,
        S_TXW
    } ctrl_state_t;

    localparam int NUM_PIXELS = 784;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/snn_ctrl.sv
// Top-level sequencer: unpacks UART image bytes into the 1-bit input RAM,
// runs snn_core, and sends the classified digit back as ASCII.
module snn_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_BYTES = NUM_PIXELS / 8,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_data,
    output logic              core_start,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [7:0]        led,
    output logic              ovr
);

    localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

    ctrl_state_t state_reg, state_next;
    logic [6:0]  byte_cnt_reg, byte_cnt_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [3:0]  digit_reg, digit_next;
    logic        ovr_reg, ovr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_RX;
            byte_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            digit_reg    <= '0;
            ovr_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            digit_reg    <= digit_next;
            ovr_reg      <= ovr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        digit_next    = digit_reg;
        ram_addr      = '0;
        ram_we        = 1'b0;
        ram_data      = 1'b0;
        core_start    = 1'b0;
        tx_start      = 1'b0;
        // A byte arriving while busy cannot be buffered, so it is flagged and lost.
        ovr_next      = ovr_reg | (rx_rdy && (state_reg != S_RX));

        case (state_reg)
            S_RX: begin
                if (rx_rdy) begin
                    shift_next   = rx_data;
                    bit_cnt_next = '0;
                    state_next   = S_WR;
                end
            end
            S_WR: begin
                ram_we       = 1'b1;
                ram_addr     = ADDR_W'({byte_cnt_reg, bit_cnt_reg});
                ram_data     = shift_reg[0];
                shift_next   = shift_reg >> 1;
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    if (byte_cnt_reg == LAST_BYTE) begin
                        state_next = S_START;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 7'd1;
                        state_next    = S_RX;
                    end
                end
            end
            S_START: begin
                core_start    = 1'b1;
                ram_addr      = core_addr;
                byte_cnt_next = '0;
                state_next    = S_RUN;
            end
            S_RUN: begin
                ram_addr = core_addr;
                if (core_done) begin
                    digit_next = core_digit;
                    state_next = S_TX;
                end
            end
            S_TX: begin
                tx_start   = 1'b1;
                state_next = S_TXW;
            end
            S_TXW: begin
                if (tx_done) begin
                    state_next = S_RX;
                end
            end
            default: begin
                state_next = S_RX;
            end
        endcase
    end

    assign tx_data = ASCII_ZERO + {4'h0, digit_reg};
    assign led     = {4'h0, digit_reg};
    assign ovr     = ovr_reg;

endmodule

// File: tb/tb_snn_ctrl.sv
// Randomized self-checking bench for snn_ctrl: captures RAM writes into a
// bench memory and compares against the image implied by the bytes sent.
module tb_snn_ctrl;
    import snn_pkg::*;

    localparam int NB = 98;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] core_addr = 10'h000;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = 4'h0;
    logic       tx_done = 1'b0;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic       ram_data;
    logic       core_start;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] led;
    logic       ovr;

    snn_ctrl #(.NUM_BYTES(NB), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .core_addr(core_addr), .core_done(core_done), .core_digit(core_digit),
        .tx_done(tx_done), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_data(ram_data), .core_start(core_start), .tx_start(tx_start),
        .tx_data(tx_data), .led(led), .ovr(ovr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_bytes [NB];
    logic [3:0] last_digit = 4'h0;
    logic       ovr_exp = 1'b0;

    // Behavioural input RAM plus write/start counters observed at negedge.
    logic mem [0:1023];
    int   wr_total = 0;
    int   start_total = 0;
    int   bad_addr = 0;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            mem[ram_addr] <= ram_data;
            wr_total <= wr_total + 1;
            if (ram_addr >= 10'd784) bad_addr <= bad_addr + 1;
        end
        if (core_start === 1'b1) start_total <= start_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_rdy = 1'b0;
        core_done = 1'b0;
        tx_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        last_digit = 4'h0;
        ovr_exp = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit inject);
        rx_data = b;
        rx_rdy = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            rx_rdy  = inject && (k == 3);
            rx_data = (inject && (k == 3)) ? ~b : 8'h00;
        end
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (ram_addr !== 10'h000) begin n_bad++; $display("FAIL reset_ram_addr got=%h want=000", ram_addr); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
        n_cmp++; if (ram_data !== 1'b0) begin n_bad++; $display("FAIL reset_ram_data got=%b want=0", ram_data); end
        n_cmp++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL reset_core_start got=%b want=0", core_start); end
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
        n_cmp++; if (tx_data !== 8'h30) begin n_bad++; $display("FAIL reset_tx_data got=%h want=30", tx_data); end
        n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL reset_led got=%h want=00", led); end
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got=%b want=0", ovr); end
        $display("reset: outputs sampled");
    endtask

    // Loads one frame; rnd=0 uses 8'hA5 everywhere; inj_idx>=0 plants an overrun.
    task automatic load_frame(input bit rnd, input int inj_idx);
        int w0 = wr_total;
        int s0 = start_total;
        int b0 = bad_addr;
        int early = 0;
        int img_bad = 0;
        logic [9:0] addr8;
        logic       we8;
        for (int i = 0; i < NB; i++) exp_bytes[i] = rnd ? 8'($urandom) : 8'hA5;
        for (int i = 0; i < NB - 1; i++) begin
            send_byte(exp_bytes[i], i == inj_idx);
            if (i == inj_idx) begin
                ovr_exp = 1'b1;
                n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL overrun_flag byte=%0d got=%b want=1", i, ovr); end
            end
        end
        rx_data = exp_bytes[NB-1];
        rx_rdy = 1'b1;
        addr8 = '0;
        we8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            rx_rdy = 1'b0;
            @(negedge clk);
            if (core_start !== 1'b0) early++;
            if (k == 8) begin addr8 = ram_addr; we8 = ram_we; end
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL start_early got=%0d want=0", early); end
        n_cmp++; if ({we8, addr8} !== {1'b1, 10'd783}) begin n_bad++; $display("FAIL last_write got=%b/%0d want=1/783", we8, addr8); end
        tick();
        core_addr = 10'($urandom);
        @(negedge clk);
        n_cmp++; if (core_start !== 1'b1) begin n_bad++; $display("FAIL start_pulse got=%b want=1", core_start); end
        n_cmp++; if ({ram_we, ram_addr} !== {1'b0, core_addr}) begin n_bad++; $display("FAIL start_arb got=%b/%h want=0/%h", ram_we, ram_addr, core_addr); end
        tick();
        @(negedge clk);
        n_cmp++; if ({core_start, ram_we} !== 2'b00) begin n_bad++; $display("FAIL start_width got=%b%b want=00", core_start, ram_we); end
        n_cmp++; if (wr_total - w0 !== 784) begin n_bad++; $display("FAIL write_count got=%0d want=784", wr_total - w0); end
        n_cmp++; if (start_total - s0 !== 1) begin n_bad++; $display("FAIL start_count got=%0d want=1", start_total - s0); end
        n_cmp++; if (bad_addr !== b0) begin n_bad++; $display("FAIL high_addr_writes got=%0d want=%0d", bad_addr, b0); end
        for (int n = 0; n < 784; n++) begin
            logic [7:0] byt;
            byt = exp_bytes[n / 8];
            if (mem[n] !== byt[n % 8]) img_bad++;
        end
        n_cmp++; if (img_bad !== 0) begin n_bad++; $display("FAIL ram_image bad_bits=%0d want=0", img_bad); end
        n_cmp++; if (ovr !== ovr_exp) begin n_bad++; $display("FAIL frame_ovr got=%b want=%b", ovr, ovr_exp); end
        $display("frame: byte0=%h byte97=%h writes=%0d image_bad_bits=%0d", exp_bytes[0], exp_bytes[NB-1], wr_total - w0, img_bad);
    endtask

    // Called in S_RUN; pre_high means core_done was already held during the load.
    task automatic test_run_result(input logic [3:0] d, input bit pre_high);
        int arb_bad = 0;
        int hold_bad = 0;
        if (!pre_high) begin
            int n = $urandom_range(2, 6);
            for (int j = 0; j < n; j++) begin
                core_addr = (j == 0) ? 10'h1F3 : 10'($urandom);
                tx_done = (j == 1);
                #1;
                if (j == 0) begin
                    n_cmp++; if ({ram_we, ram_addr} !== {1'b0, 10'h1F3}) begin n_bad++; $display("FAIL arb_1f3 got=%b/%h want=0/1f3", ram_we, ram_addr); end
                end
                if (ram_addr !== core_addr || ram_we !== 1'b0 || tx_start !== 1'b0) arb_bad++;
                tick();
            end
            tx_done = 1'b0;
            n_cmp++; if (arb_bad !== 0) begin n_bad++; $display("FAIL arb_run bad_cycles=%0d want=0", arb_bad); end
            core_done = 1'b1;
            core_digit = d;
        end else begin
            n_cmp++; if (led !== {4'h0, last_digit}) begin n_bad++; $display("FAIL done_ignored led=%h want=%h", led, {4'h0, last_digit}); end
        end
        tick();
        core_done = 1'b0;
        core_digit = 4'($urandom);
        @(negedge clk);
        n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL tx_start got=%b want=1", tx_start); end
        n_cmp++; if (tx_data !== 8'h30 + {4'h0, d}) begin n_bad++; $display("FAIL tx_data got=%h want=%h", tx_data, 8'h30 + {4'h0, d}); end
        n_cmp++; if (led !== {4'h0, d}) begin n_bad++; $display("FAIL led got=%h want=%h", led, {4'h0, d}); end
        last_digit = d;
        repeat ($urandom_range(1, 5)) begin
            tick();
            @(negedge clk);
            if (tx_start !== 1'b0 || tx_data !== 8'h30 + {4'h0, d}) hold_bad++;
        end
        n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL tx_hold bad_cycles=%0d want=0", hold_bad); end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        $display("result: digit=%0d tx_data=%h led=%h", d, tx_data, led);
    endtask

    task automatic test_overrun();
        do_reset();
        load_frame(1'b1, 5);
        test_run_result(4'($urandom_range(0, 9)), 1'b0);
        n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got=%b want=1", ovr); end
        do_reset();
        @(negedge clk);
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got=%b want=0", ovr); end
        $display("overrun: sticky flag exercised");
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int i = 0; i <= 40; i++) send_byte(8'($urandom), 1'b0);
        rx_data = 8'($urandom);
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (2) tick();
        do_reset();
        load_frame(1'b1, -1);
        test_run_result(4'($urandom_range(0, 9)), 1'b0);
        $display("reset_mid_load: frame reloaded from address 0");
    endtask

    initial begin
        logic [3:0] d2;
        test_reset();
        load_frame(1'b0, -1);
        test_run_result(4'd7, 1'b0);
        d2 = 4'($urandom_range(0, 9));
        core_done = 1'b1;
        core_digit = d2;
        load_frame(1'b1, -1);
        test_run_result(d2, 1'b1);
        test_overrun();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
